// File: rtl/text_mode_scanner.sv
// Character-cell text renderer: maps video timing to a character buffer,
// drives an external font ROM and re-times its pixel with a blinking cursor.
module text_mode_scanner #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [6:0]  wr_data,
  input  logic        cursor_en,
  input  logic [11:0] cursor_addr,
  output logic [6:0]  ascii_code,
  output logic [3:0]  row,
  output logic [2:0]  col,
  input  logic        row_of_pixels,
  output logic        pix_out,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out
);

  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned PX_W   = 11;
  localparam int unsigned LN_W   = 10;
  localparam int unsigned CX_W   = PX_W - 3;
  localparam int unsigned CY_W   = LN_W - 4;
  localparam int unsigned CHAR_W = 7;
  localparam int unsigned FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PX_W-1:0] PX_MAX = '1;

  logic [PX_W-1:0]   px_q, px_d;
  logic [LN_W-1:0]   ln_q, ln_d;
  logic              de_prev_q, de_prev_d;
  logic              vs_prev_q, vs_prev_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic              blink_q, blink_d;
  logic [CHAR_W-1:0] rd_q, rd_d;
  logic [3:0]        row_q, row_d;
  logic [2:0]        col_q, col_d;
  logic              vis1_q, vis1_d;
  logic              hit1_q, hit1_d;
  logic              vis2_q, vis2_d;
  logic              hit2_q, hit2_d;
  logic [2:0]        tim1_q, tim1_d;
  logic [2:0]        tim2_q, tim2_d;
  logic [2:0]        tim3_q, tim3_d;
  logic              pix_q, pix_d;

  logic [CHAR_W-1:0] mem [CELLS];

  logic              vs_rise, de_fall;
  logic [CX_W-1:0]   cell_x;
  logic [CY_W-1:0]   cell_y;
  logic [ADDR_W-1:0] cell_idx;
  logic              in_range, rd_en, cursor_ok, wr_ok;

  // Raster position, blink timing and the three-stage render pipeline.
  always_comb begin
    vs_rise   = vs_in & ~vs_prev_q;
    de_fall   = ~de_in & de_prev_q;
    de_prev_d = de_in;
    vs_prev_d = vs_in;

    px_d = '0;
    if (de_in) px_d = (px_q == PX_MAX) ? px_q : px_q + PX_W'(1);

    ln_d = ln_q;
    if (vs_rise)      ln_d = '0;
    else if (de_fall) ln_d = ln_q + LN_W'(1);

    fc_d    = fc_q;
    blink_d = blink_q;
    if (vs_rise) begin
      if (32'(fc_q) == BLINK_FRAMES - 1) begin
        fc_d    = '0;
        blink_d = ~blink_q;
      end else begin
        fc_d = fc_q + FC_W'(1);
      end
    end

    cell_x   = px_q[PX_W-1:3];
    cell_y   = ln_q[LN_W-1:4];
    in_range = (32'(cell_x) < COLS) && (32'(cell_y) < ROWS);
    cell_idx = ADDR_W'(32'(cell_y) * COLS + 32'(cell_x));
    rd_en    = de_in & in_range;

    rd_d   = rd_en ? mem[cell_idx] : '0;
    row_d  = ln_q[3:0];
    col_d  = px_q[2:0];
    vis1_d = rd_en;

    // Cursor underline on glyph rows 14-15 of the addressed cell.
    cursor_ok = 32'(cursor_addr) < CELLS;
    hit1_d    = cursor_en & blink_q & cursor_ok & rd_en &
                (cell_idx == cursor_addr) & (ln_q[3:1] == 3'b111);

    tim1_d = {de_in, hs_in, vs_in};
    tim2_d = tim1_q;
    tim3_d = tim2_q;
    vis2_d = vis1_q;
    hit2_d = hit1_q;
    pix_d  = vis2_q & (row_of_pixels ^ hit2_q);

    wr_ok = wr_en & ~rst & (32'(wr_addr) < CELLS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px_q      <= '0;
      ln_q      <= '0;
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      fc_q      <= '0;
      blink_q   <= 1'b0;
      rd_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      vis1_q    <= 1'b0;
      hit1_q    <= 1'b0;
      vis2_q    <= 1'b0;
      hit2_q    <= 1'b0;
      tim1_q    <= '0;
      tim2_q    <= '0;
      tim3_q    <= '0;
      pix_q     <= 1'b0;
    end else begin
      px_q      <= px_d;
      ln_q      <= ln_d;
      de_prev_q <= de_prev_d;
      vs_prev_q <= vs_prev_d;
      fc_q      <= fc_d;
      blink_q   <= blink_d;
      rd_q      <= rd_d;
      row_q     <= row_d;
      col_q     <= col_d;
      vis1_q    <= vis1_d;
      hit1_q    <= hit1_d;
      vis2_q    <= vis2_d;
      hit2_q    <= hit2_d;
      tim1_q    <= tim1_d;
      tim2_q    <= tim2_d;
      tim3_q    <= tim3_d;
      pix_q     <= pix_d;
    end
  end

  // Character buffer contents survive reset; read-first comes from the registered read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  assign ascii_code = rd_q;
  assign row        = row_q;
  assign col        = col_q;
  assign pix_out    = pix_q;
  assign de_out     = tim3_q[2];
  assign hs_out     = tim3_q[1];
  assign vs_out     = tim3_q[0];

endmodule
